haar_param_loader: RTL and testbench

- Loads Haar cascade parameters from a byte-wide valid/ready stream into three per-stage parameter register files.
- Presents the register files as flat buses that the first-phase classifier consumes as its stage-1/2/3 ROM contents.
- Asserts params_ready once all three stages are loaded, which enables classification.
- Supports reload at runtime and flags malformed streams.

---
 rtl/haar_param_loader_if.sv | 13 +
 rtl/haar_param_loader.sv | 165 ++++++++++++++++
 tb/tb_haar_param_loader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/haar_param_loader_if.sv
// Byte-wide valid/ready parameter stream between the loader and its source.
// in_last marks the final word of the whole cascade image.
interface haar_param_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/haar_param_loader.sv
// Loads three Haar cascade stages from a word stream into flat parameter buses,
// raising params_ready on a well-framed load and load_error on a framing fault.
module haar_param_loader #(
    parameter int DATA_WIDTH                   = 8,
    parameter int NUM_STAGE_THRESHOLD          = 1,
    parameter int NUM_PARAM_PER_CLASSIFIER     = 18,
    parameter int NUM_CLASSIFIERS_FIRST_STAGE  = 10,
    parameter int NUM_CLASSIFIERS_SECOND_STAGE = 10,
    parameter int NUM_CLASSIFIERS_THIRD_STAGE  = 10,
    localparam int W1 = NUM_CLASSIFIERS_FIRST_STAGE  * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD,
    localparam int W2 = NUM_CLASSIFIERS_SECOND_STAGE * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD,
    localparam int W3 = NUM_CLASSIFIERS_THIRD_STAGE  * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD,
    localparam int CNT_W = $clog2(W1 + W2 + W3 + 1)
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     start,
    haar_param_loader_if.slave       s_in,
    output logic [DATA_WIDTH*W1-1:0] rom_stage1,
    output logic [DATA_WIDTH*W2-1:0] rom_stage2,
    output logic [DATA_WIDTH*W3-1:0] rom_stage3,
    output logic                     params_ready,
    output logic                     load_error,
    output logic [CNT_W-1:0]         words_loaded
);
    localparam int WMAX  = (W1 > W2) ? ((W1 > W3) ? W1 : W3) : ((W2 > W3) ? W2 : W3);
    localparam int IDX_W = $clog2(WMAX);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_S1,
        LOAD_S2,
        LOAD_S3,
        DONE,
        ERROR
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IDX_W-1:0]      r_index;
    logic [CNT_W-1:0]      r_words;
    logic                  r_params_ready;
    logic                  r_load_error;
    logic [DATA_WIDTH-1:0] r_rom1 [W1];
    logic [DATA_WIDTH-1:0] r_rom2 [W2];
    logic [DATA_WIDTH-1:0] r_rom3 [W3];

    logic w_in_ready;
    logic w_accept;
    logic w_stage_end;
    logic w_load_start;

    always_comb begin
        w_in_ready = (r_state == LOAD_S1) || (r_state == LOAD_S2) || (r_state == LOAD_S3);
    end

    assign s_in.in_ready = w_in_ready;
    assign w_accept      = s_in.in_valid && w_in_ready;
    assign w_load_start  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));

    // Full-width compare against the active stage's last index.
    always_comb begin
        w_stage_end = 1'b0;
        case (r_state)
            LOAD_S1: w_stage_end = (r_index == IDX_W'(W1 - 1));
            LOAD_S2: w_stage_end = (r_index == IDX_W'(W2 - 1));
            LOAD_S3: w_stage_end = (r_index == IDX_W'(W3 - 1));
            default: w_stage_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    w_state_next = LOAD_S1;
                end
            end
            LOAD_S1: begin
                if (w_accept) begin
                    if (s_in.in_last)     w_state_next = ERROR;
                    else if (w_stage_end) w_state_next = LOAD_S2;
                end
            end
            LOAD_S2: begin
                if (w_accept) begin
                    if (s_in.in_last)     w_state_next = ERROR;
                    else if (w_stage_end) w_state_next = LOAD_S3;
                end
            end
            LOAD_S3: begin
                if (w_accept) begin
                    if (w_stage_end)        w_state_next = s_in.in_last ? DONE : ERROR;
                    else if (s_in.in_last)  w_state_next = ERROR;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Status flags mirror the state being entered so they are registered outputs.
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            r_params_ready <= 1'b0;
            r_load_error   <= 1'b0;
            r_words        <= '0;
            r_index        <= '0;
        end else begin
            r_params_ready <= (w_state_next == DONE);
            r_load_error   <= (w_state_next == ERROR);
            if (w_load_start) begin
                r_words <= '0;
                r_index <= '0;
            end else if (w_accept) begin
                r_words <= r_words + CNT_W'(1);
                r_index <= w_stage_end ? '0 : r_index + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            for (int k = 0; k < W1; k++) r_rom1[k] <= '0;
            for (int k = 0; k < W2; k++) r_rom2[k] <= '0;
            for (int k = 0; k < W3; k++) r_rom3[k] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < W1; k++) begin
                if ((r_state == LOAD_S1) && (r_index == IDX_W'(k))) r_rom1[k] <= s_in.in_data;
            end
            for (int k = 0; k < W2; k++) begin
                if ((r_state == LOAD_S2) && (r_index == IDX_W'(k))) r_rom2[k] <= s_in.in_data;
            end
            for (int k = 0; k < W3; k++) begin
                if ((r_state == LOAD_S3) && (r_index == IDX_W'(k))) r_rom3[k] <= s_in.in_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < W1; gi++) begin : g_pack1
            assign rom_stage1[gi*DATA_WIDTH +: DATA_WIDTH] = r_rom1[gi];
        end
        for (gi = 0; gi < W2; gi++) begin : g_pack2
            assign rom_stage2[gi*DATA_WIDTH +: DATA_WIDTH] = r_rom2[gi];
        end
        for (gi = 0; gi < W3; gi++) begin : g_pack3
            assign rom_stage3[gi*DATA_WIDTH +: DATA_WIDTH] = r_rom3[gi];
        end
    endgenerate

    assign params_ready = r_params_ready;
    assign load_error   = r_load_error;
    assign words_loaded = r_words;
endmodule

// File: tb/tb_haar_param_loader.sv
// Randomized stream bench for haar_param_loader: completion events are
// scoreboarded against a flat 543-word image model of the parameter store.
module tb_haar_param_loader;
    localparam int W1    = 181;
    localparam int W2    = 181;
    localparam int W3    = 181;
    localparam int TOTAL = W1 + W2 + W3;

    logic                 clk_fpga;
    logic                 reset_fpga;
    logic                 start;
    logic [8*W1-1:0]      rom_stage1;
    logic [8*W2-1:0]      rom_stage2;
    logic [8*W3-1:0]      rom_stage3;
    logic                 params_ready;
    logic                 load_error;
    logic [9:0]           words_loaded;

    haar_param_loader_if #(.DATA_WIDTH(8)) u_if ();

    haar_param_loader u_dut (
        .clk_fpga     (clk_fpga),
        .reset_fpga   (reset_fpga),
        .start        (start),
        .s_in         (u_if),
        .rom_stage1   (rom_stage1),
        .rom_stage2   (rom_stage2),
        .rom_stage3   (rom_stage3),
        .params_ready (params_ready),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk_fpga = 1'b0;
    always #5 clk_fpga = ~clk_fpga;

    typedef struct {
        bit                 is_done;
        int                 words;
        int                 cyc;
        logic [8*TOTAL-1:0] image;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  model_mem [TOTAL];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ready_bad = 0;
    logic        pr_prev = 1'b0;
    logic        le_prev = 1'b0;

    always @(posedge clk_fpga) cyc = cyc + 1;

    function automatic logic [8*TOTAL-1:0] model_image();
        logic [8*TOTAL-1:0] s;
        for (int k = 0; k < TOTAL; k++) s[k*8 +: 8] = model_mem[k];
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic chk_image(input string name, input logic [8*TOTAL-1:0] exp);
        logic [8*TOTAL-1:0] act;
        int bad;
        act = {rom_stage3, rom_stage2, rom_stage1};
        bad = -1;
        for (int k = TOTAL - 1; k >= 0; k--) if (act[k*8 +: 8] !== exp[k*8 +: 8]) bad = k;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("[TB] FAIL %s: word %0d got 0x%0h, expected 0x%0h",
                     name, bad, act[bad*8 +: 8], exp[bad*8 +: 8]);
        end else begin
            $display("[TB] ok   %s: all %0d words match", name, TOTAL);
        end
    endtask

    // Monitor: each rising completion flag consumes one expected outcome.
    always @(negedge clk_fpga) begin
        if (!reset_fpga && ((params_ready && !pr_prev) || (load_error && !le_prev))) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_event: got pr=%0b le=%0b, expected no event",
                         params_ready, load_error);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("evt_params_ready", params_ready, e.is_done);
                chk("evt_load_error", load_error, !e.is_done);
                chk("evt_words_loaded", words_loaded, e.words);
                chk("evt_latency_cycle", cyc, e.cyc);
                chk_image("evt_rom_image", e.image);
            end
        end
        pr_prev = params_ready;
        le_prev = load_error;
    end

    task automatic pulse_start();
        @(negedge clk_fpga);
        start = 1'b1;
        @(posedge clk_fpga);
        #1;
        start = 1'b0;
    endtask

    task automatic drive_word(input logic [7:0] data, input bit last, input int vprob,
                              input bit do_start, input bit do_stall, output bit ok);
        int  tries;
        int  stall;
        bit  v;
        bit  rdy;
        bit  acc;
        tries = 0;
        stall = do_stall ? 4 : 0;
        acc   = 1'b0;
        ok    = 1'b1;
        while (!acc) begin
            @(negedge clk_fpga);
            if (stall > 0) begin
                v = 1'b0;
                stall--;
            end else begin
                v = ($urandom_range(99) < vprob) || (tries > 40);
            end
            u_if.in_valid = v;
            u_if.in_data  = v ? data : 8'($urandom);
            u_if.in_last  = v ? last : 1'($urandom);
            start         = do_start && (tries == 0);
            rdy           = u_if.in_ready;
            if (!rdy) ready_bad++;
            @(posedge clk_fpga);
            #1;
            start = 1'b0;
            if (v && rdy) acc = 1'b1;
            tries++;
            if (!acc && tries > 200) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL accept_timeout: got no acceptance in %0d cycles, expected one", tries);
                ok = 1'b0;
                return;
            end
        end
    endtask

    // Spec-level stream: words written in order; a load ends on the first in_last
    // or on word TOTAL-1, done only if both coincide.
    task automatic send_stream(input int last_pos, input int vprob, input int start_at,
                               input int stall_at, input int abort_at, input bit rand_data);
        logic [7:0] d;
        bit         last;
        bit         ok;
        exp_t       e;
        for (int k = 0; k < TOTAL; k++) begin
            d    = rand_data ? 8'($urandom) : 8'(k % 256);
            last = (k == last_pos);
            drive_word(d, last, vprob, k == start_at, k == stall_at, ok);
            if (!ok) return;
            model_mem[k] = d;
            if (k == abort_at) return;
            if (last || k == TOTAL - 1) begin
                e.is_done = last && (k == TOTAL - 1);
                e.words   = k + 1;
                e.cyc     = cyc;
                e.image   = model_image();
                exp_q.push_back(e);
                @(negedge clk_fpga);
                u_if.in_valid = 1'b0;
                u_if.in_last  = 1'b0;
                return;
            end
        end
    endtask

    task automatic expect_drained(input string name);
        repeat (3) @(negedge clk_fpga);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [8*TOTAL-1:0] img;
        for (int k = 0; k < TOTAL; k++) model_mem[k] = 8'h00;
        reset_fpga    = 1'b1;
        start         = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        u_if.in_data  = 8'h00;
        repeat (3) @(negedge clk_fpga);
        chk("rst_in_ready", u_if.in_ready, 0);
        chk("rst_params_ready", params_ready, 0);
        chk("rst_load_error", load_error, 0);
        chk("rst_words_loaded", words_loaded, 0);
        chk_image("rst_rom_zero", '0);
        reset_fpga = 1'b0;

        // 1: full stream, valid held high
        pulse_start();
        send_stream(TOTAL - 1, 100, -1, -1, -1, 1'b0);
        expect_drained("s1_event_seen");
        img = {rom_stage3, rom_stage2, rom_stage1};
        chk("s1_rom1_w0", img[0*8 +: 8], 8'h00);
        chk("s1_rom1_w180", img[180*8 +: 8], 8'hB4);
        chk("s1_rom2_w0", img[181*8 +: 8], 8'hB5);
        chk("s1_rom3_w180", img[542*8 +: 8], 8'h1E);
        chk("s1_words_loaded", words_loaded, 543);

        // 2: random valid gaps, stall at the stage boundary
        ready_bad = 0;
        pulse_start();
        send_stream(TOTAL - 1, 60, -1, 180, -1, 1'b0);
        expect_drained("s2_event_seen");
        chk("s2_ready_held", ready_bad, 0);

        // 3: early in_last on word 100
        pulse_start();
        send_stream(99, 70, -1, -1, -1, 1'b1);
        expect_drained("s3_event_seen");
        chk("s3_in_ready_low", u_if.in_ready, 0);
        repeat (5) begin
            @(negedge clk_fpga);
            u_if.in_valid = 1'b1;
            u_if.in_data  = 8'($urandom);
            u_if.in_last  = 1'($urandom);
        end
        @(negedge clk_fpga);
        u_if.in_valid = 1'b0;
        chk("s3_words_held", words_loaded, 100);
        chk("s3_error_held", load_error, 1);
        chk_image("s3_rom_unchanged", model_image());

        // 4: missing in_last on final word, then a good reload
        pulse_start();
        send_stream(-1, 80, -1, -1, -1, 1'b1);
        expect_drained("s4_event_seen");
        pulse_start();
        send_stream(TOTAL - 1, 80, -1, -1, -1, 1'b1);
        expect_drained("s4_reload_event_seen");
        chk("s4_reload_error_clear", load_error, 0);

        // 5: start mid-load is ignored
        pulse_start();
        send_stream(TOTAL - 1, 90, 50, -1, -1, 1'b1);
        expect_drained("s5_event_seen");
        chk("s5_words_loaded", words_loaded, 543);

        // 6: asynchronous reset between edges at word 300
        pulse_start();
        send_stream(TOTAL - 1, 100, -1, -1, 300, 1'b1);
        #2;
        reset_fpga = 1'b1;
        #1;
        chk("s6_in_ready", u_if.in_ready, 0);
        chk("s6_params_ready", params_ready, 0);
        chk("s6_load_error", load_error, 0);
        chk("s6_words_loaded", words_loaded, 0);
        chk_image("s6_rom_cleared", '0);
        for (int k = 0; k < TOTAL; k++) model_mem[k] = 8'h00;
        u_if.in_valid = 1'b0;
        @(negedge clk_fpga);
        reset_fpga = 1'b0;
        pulse_start();
        send_stream(TOTAL - 1, 75, -1, -1, -1, 1'b1);
        expect_drained("s6_reload_event_seen");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
